accum_mem_ctrl: RTL and testbench

Address/enable generator for the accumulator (output) memory banks on the drain side of the systolic array. The input side issues skewed reads. This block receives the array's skewed column outputs and issues de-skewed per-column writes, with an optional accumulate flag, into SYS_COL banks. It then drains the banks to the host side with parallel, aligned reads. It sits between the systolic array's bottom edge and the accumulator SRAM banks, and is driven by the top-level sequencer.

---
 rtl/accum_mem_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_accum_mem_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_mem_ctrl.sv
// accum_mem_ctrl
// Address/enable generator for the accumulator SRAM banks that sit below the
// systolic array. A write collects the array's skewed column outputs: column j
// is written one cycle after column j-1, rows 0..N-1 at addresses 0..N-1,
// optionally in accumulate mode. A read drains all banks in parallel with one
// shared, aligned address.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   wr_start_in  one-cycle pulse, starts collection of num_row skewed rows
//   accum_in     sampled with wr_start_in: 1 = add into bank, 0 = overwrite
//   rd_start_in  one-cycle pulse, starts a parallel drain of num_row rows
//   num_row      row count, clamped to ACCUM_ROW, sampled on an accepted start
//   wr_en        per-bank write enable
//   wr_addr      per-bank write address, bank j at [j*8 +: 8]
//   wr_accum     per-bank accumulate qualifier
//   rd_en        per-bank read enable
//   rd_addr      per-bank read address, bank j at [j*8 +: 8]
//   busy         high while a write or read is issuing enables
//   wr_done      one-cycle pulse, collection complete
//   rd_done      one-cycle pulse, drain complete
module accum_mem_ctrl #(
  parameter int SYS_COL    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ACCUM_ROW  = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_start_in,
  input  logic                    accum_in,
  input  logic                    rd_start_in,
  input  logic [DATA_WIDTH-1:0]   num_row,
  output logic [SYS_COL-1:0]      wr_en,
  output logic [SYS_COL*8-1:0]    wr_addr,
  output logic [SYS_COL-1:0]      wr_accum,
  output logic [SYS_COL-1:0]      rd_en,
  output logic [SYS_COL*8-1:0]    rd_addr,
  output logic                    busy,
  output logic                    wr_done,
  output logic                    rd_done
);

  localparam int COUNT_WIDTH = $clog2(ACCUM_ROW + SYS_COL) + 1;

  localparam logic [DATA_WIDTH-1:0]  ROW_MAX_D = DATA_WIDTH'(ACCUM_ROW);
  localparam logic [COUNT_WIDTH-1:0] ROW_MAX_C = COUNT_WIDTH'(ACCUM_ROW);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] WR_TAIL   = COUNT_WIDTH'(SYS_COL - 1);
  localparam logic [SYS_COL-1:0]     COL0_ONLY = SYS_COL'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t                 state_r;
  logic [COUNT_WIDTH-1:0] cnt_r;        // cycles spent in WRITE/READ, 1 in the first
  logic [COUNT_WIDTH-1:0] n_rows_r;
  logic                   accum_r;

  logic [COUNT_WIDTH-1:0] n_clamped_s;
  logic                   shift_in_s;
  logic [SYS_COL-1:0]     wr_en_next_s;
  logic [7:0]             addr_next_s;
  logic                   wr_last_s;
  logic                   rd_last_s;

  // Next-cycle helpers: clamped row count and the column-0 shift-in row.
  always_comb begin
    n_clamped_s = COUNT_WIDTH'(num_row);
    if (num_row > ROW_MAX_D) begin
      n_clamped_s = ROW_MAX_C;
    end else begin
      n_clamped_s = COUNT_WIDTH'(num_row);
    end
    // cnt_r equals the index of the row column 0 would issue next cycle
    shift_in_s   = (cnt_r < n_rows_r);
    wr_en_next_s = {wr_en[SYS_COL-2:0], shift_in_s};
    addr_next_s  = 8'd0;
    if (shift_in_s) begin
      addr_next_s = 8'(cnt_r);
    end else begin
      addr_next_s = 8'd0;
    end
    // column SYS_COL-1 issues its last row N+SYS_COL-1 cycles after the start
    wr_last_s = (cnt_r == (n_rows_r + WR_TAIL));
    rd_last_s = (cnt_r == n_rows_r);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      n_rows_r <= '0;
      accum_r  <= 1'b0;
      wr_en    <= '0;
      wr_addr  <= '0;
      wr_accum <= '0;
      rd_en    <= '0;
      rd_addr  <= '0;
      busy     <= 1'b0;
      wr_done  <= 1'b0;
      rd_done  <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r    <= '0;
          wr_en    <= '0;
          wr_addr  <= '0;
          wr_accum <= '0;
          rd_en    <= '0;
          rd_addr  <= '0;
          busy     <= 1'b0;
          // a write wins over a simultaneous read
          if (wr_start_in) begin
            n_rows_r <= n_clamped_s;
            accum_r  <= accum_in;
            if (n_clamped_s == '0) begin
              wr_done <= 1'b1;
            end else begin
              state_r  <= WRITE;
              busy     <= 1'b1;
              cnt_r    <= CNT_ONE;
              wr_en    <= COL0_ONLY;
              wr_accum <= accum_in ? COL0_ONLY : '0;
            end
          end else if (rd_start_in) begin
            n_rows_r <= n_clamped_s;
            if (n_clamped_s == '0) begin
              rd_done <= 1'b1;
            end else begin
              state_r <= READ;
              busy    <= 1'b1;
              cnt_r   <= CNT_ONE;
              rd_en   <= '1;
            end
          end else begin
            n_rows_r <= n_rows_r;
          end
        end
        WRITE: begin
          if (wr_last_s) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            busy     <= 1'b0;
            wr_done  <= 1'b1;
            wr_en    <= '0;
            wr_addr  <= '0;
            wr_accum <= '0;
          end else begin
            cnt_r    <= cnt_r + CNT_ONE;
            // de-skew: column j repeats column j-1's enable and address a cycle later
            wr_en    <= wr_en_next_s;
            wr_addr  <= {wr_addr[SYS_COL*8-9:0], addr_next_s};
            wr_accum <= accum_r ? wr_en_next_s : '0;
          end
        end
        READ: begin
          if (rd_last_s) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy    <= 1'b0;
            rd_done <= 1'b1;
            rd_en   <= '0;
            rd_addr <= '0;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            rd_addr <= {SYS_COL{8'(cnt_r)}};
          end
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= '0;
          busy     <= 1'b0;
          wr_en    <= '0;
          wr_addr  <= '0;
          wr_accum <= '0;
          rd_en    <= '0;
          rd_addr  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_mem_ctrl.sv
module tb_accum_mem_ctrl;

  localparam int SC = 4;
  localparam int AR = 8;
  localparam int MAXOPS = 1024;

  logic        clk;
  logic        rst;
  logic        wr_start_in;
  logic        accum_in;
  logic        rd_start_in;
  logic [15:0] num_row;
  logic [3:0]  wr_en;
  logic [31:0] wr_addr;
  logic [3:0]  wr_accum;
  logic [3:0]  rd_en;
  logic [31:0] rd_addr;
  logic        busy;
  logic        wr_done;
  logic        rd_done;

  accum_mem_ctrl #(.SYS_COL(SC), .DATA_WIDTH(16), .ACCUM_ROW(AR)) dut (
    .clk(clk), .rst(rst), .wr_start_in(wr_start_in), .accum_in(accum_in),
    .rd_start_in(rd_start_in), .num_row(num_row), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_accum(wr_accum), .rd_en(rd_en), .rd_addr(rd_addr),
    .busy(busy), .wr_done(wr_done), .rd_done(rd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: list of accepted operations, each described by kind,
  // start cycle, clamped row count, accumulate flag and the cycle a reset hit it.
  int op_kind [MAXOPS];
  int op_t    [MAXOPS];
  int op_n    [MAXOPS];
  int op_kill [MAXOPS];
  bit op_a    [MAXOPS];
  int n_ops = 0;

  logic [3:0]  e_wr_en, e_wr_acc, e_rd_en;
  logic [31:0] e_wr_addr, e_rd_addr;
  logic        e_busy, e_wr_done, e_rd_done;
  logic [78:0] exp_v;
  logic [78:0] dut_v;
  assign dut_v = {wr_en, wr_addr, wr_accum, rd_en, rd_addr, busy, wr_done, rd_done};

  function automatic int last_active(input int i);
    return (op_kind[i] == 1) ? op_t[i] + op_n[i] + SC - 1 : op_t[i] + op_n[i];
  endfunction

  function automatic bit model_busy(input int c);
    for (int i = 0; i < n_ops; i++) begin
      if (op_n[i] > 0 && c >= op_t[i] + 1 && c <= last_active(i) && c <= op_kill[i])
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_start(input int c, input logic w, input logic r, input logic a,
                             input logic [15:0] n);
    if (model_busy(c) || n_ops >= MAXOPS || !(w || r)) return;
    op_kind[n_ops] = w ? 1 : 2;
    op_t[n_ops]    = c;
    op_n[n_ops]    = (int'(n) > AR) ? AR : int'(n);
    op_a[n_ops]    = w ? a : 1'b0;
    op_kill[n_ops] = 32'h3fffffff;
    n_ops++;
  endtask

  task automatic model_eval(input int c);
    e_wr_en = '0; e_wr_acc = '0; e_rd_en = '0; e_wr_addr = '0; e_rd_addr = '0;
    e_busy = 1'b0; e_wr_done = 1'b0; e_rd_done = 1'b0;
    for (int i = 0; i < n_ops; i++) begin
      if (c <= op_kill[i] && c >= op_t[i] + 1) begin
        if (op_kind[i] == 1) begin
          for (int j = 0; j < SC; j++) begin
            if (c >= op_t[i] + 1 + j && c <= op_t[i] + op_n[i] + j) begin
              e_wr_en[j] = 1'b1;
              e_wr_acc[j] = op_a[i];
              e_wr_addr[j*8 +: 8] = 8'(c - op_t[i] - 1 - j);
            end
          end
          if (op_n[i] > 0 && c <= last_active(i)) e_busy = 1'b1;
          if (c == ((op_n[i] == 0) ? op_t[i] + 1 : op_t[i] + op_n[i] + SC)) e_wr_done = 1'b1;
        end else begin
          if (c <= op_t[i] + op_n[i]) begin
            e_rd_en = 4'hF;
            e_busy = 1'b1;
            for (int j = 0; j < SC; j++) e_rd_addr[j*8 +: 8] = 8'(c - op_t[i] - 1);
          end
          if (c == op_t[i] + op_n[i] + 1) e_rd_done = 1'b1;
        end
      end
    end
    exp_v = {e_wr_en, e_wr_addr, e_wr_acc, e_rd_en, e_rd_addr, e_busy, e_wr_done, e_rd_done};
  endtask

  // Advance one cycle: drive this cycle's inputs, record them in the model,
  // then wait for the opposite edge so outputs can be sampled.
  task automatic tick(input logic w, input logic r, input logic a,
                      input logic [15:0] n, input logic rs);
    @(posedge clk);
    cyc++;
    #1;
    rst = rs; wr_start_in = w; rd_start_in = r; accum_in = a; num_row = n;
    if (rs) begin
      for (int i = 0; i < n_ops; i++) if (op_kill[i] > cyc) op_kill[i] = cyc;
    end else begin
      model_start(cyc, w, r, a, n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b0, 1'b0, 16'd0, (k < 3));
      total++;
      if (dut_v !== 79'd0) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%h want=0", cyc, dut_v);
      end
    end
  endtask

  task automatic test_write_overwrite();
    int t;
    tick(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 16'd3, 1'b0);
    t = cyc;
    for (int k = 1; k <= 9; k++) begin
      tick(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      model_eval(cyc);
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL wr_ovr_model cyc=%0d got=%h want=%h", cyc, dut_v, exp_v);
      end
      total++;
      if ({wr_en[0], wr_en[3], wr_accum, wr_done} !==
          {(k >= 1 && k <= 3), (k >= 4 && k <= 6), 4'b0000, (k == 7)}) begin
        bad++;
        $display("FAIL wr_ovr_spot cyc=%0d en0=%b en3=%b acc=%b done=%b", cyc,
                 wr_en[0], wr_en[3], wr_accum, wr_done);
      end
      if (k >= 3 && k <= 5) begin
        total++;
        if (wr_addr[23:16] !== 8'(k - 3)) begin
          bad++;
          $display("FAIL wr_ovr_addr2 cyc=%0d got=%0d want=%0d", cyc, wr_addr[23:16], k - 3);
        end
      end
    end
  endtask

  task automatic test_write_accum();
    tick(1'b1, 1'b0, 1'b1, 16'd2, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      model_eval(cyc);
      total++;
      if (dut_v !== exp_v || wr_accum !== e_wr_en) begin
        bad++;
        $display("FAIL wr_acc cyc=%0d got=%h want=%h acc=%b", cyc, dut_v, exp_v, wr_accum);
      end
    end
  endtask

  task automatic test_read();
    tick(1'b0, 1'b1, 1'b0, 16'd8, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      model_eval(cyc);
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL rd_model cyc=%0d got=%h want=%h", cyc, dut_v, exp_v);
      end
      total++;
      if (rd_en !== ((k <= 8) ? 4'hF : 4'h0) || rd_done !== (k == 9) ||
          (k <= 8 && rd_addr !== {4{8'(k - 1)}})) begin
        bad++;
        $display("FAIL rd_spot cyc=%0d en=%h addr=%h done=%b", cyc, rd_en, rd_addr, rd_done);
      end
    end
  endtask

  task automatic test_clamp_zero();
    int cnt_col [SC];
    for (int j = 0; j < SC; j++) cnt_col[j] = 0;
    tick(1'b1, 1'b0, 1'b0, 16'd20, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      tick(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      for (int j = 0; j < SC; j++) if (wr_en[j] === 1'b1) cnt_col[j]++;
      model_eval(cyc);
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL clamp_model cyc=%0d got=%h want=%h", cyc, dut_v, exp_v);
      end
    end
    for (int j = 0; j < SC; j++) begin
      total++;
      if (cnt_col[j] != 8) begin
        bad++;
        $display("FAIL clamp_count col=%0d got=%0d want=8", j, cnt_col[j]);
      end
    end
    tick(1'b1, 1'b0, 1'b1, 16'd0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    total++;
    if (dut_v !== {75'd0, 4'b0010}) begin
      bad++;
      $display("FAIL zero_wr cyc=%0d got=%h want wr_done only", cyc, dut_v);
    end
    tick(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    total++;
    if (dut_v !== {75'd0, 4'b0001}) begin
      bad++;
      $display("FAIL zero_rd cyc=%0d got=%h want rd_done only", cyc, dut_v);
    end
  endtask

  task automatic test_start_handling();
    tick(1'b1, 1'b1, 1'b0, 16'd2, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      tick(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      model_eval(cyc);
      total++;
      if (dut_v !== exp_v || rd_en !== 4'h0) begin
        bad++;
        $display("FAIL simul cyc=%0d got=%h want=%h", cyc, dut_v, exp_v);
      end
    end
    tick(1'b1, 1'b0, 1'b0, 16'd3, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      tick(1'b0, (k == 2) || (k == 7), 1'b0, (k == 2) ? 16'd5 : 16'd2, 1'b0);
      model_eval(cyc);
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL b2b_model cyc=%0d got=%h want=%h", cyc, dut_v, exp_v);
      end
      if (k >= 3 && k <= 8) begin
        total++;
        if (rd_en !== ((k == 8) ? 4'hF : 4'h0) || wr_done !== (k == 7)) begin
          bad++;
          $display("FAIL b2b_spot cyc=%0d rd_en=%h wr_done=%b", cyc, rd_en, wr_done);
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    tick(1'b1, 1'b0, 1'b1, 16'd6, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      tick((k == 10), 1'b0, 1'b0, (k == 10) ? 16'd2 : 16'd0, (k == 4));
      model_eval(cyc);
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL rst_mid_model cyc=%0d got=%h want=%h", cyc, dut_v, exp_v);
      end
      if (k >= 5 && k <= 10) begin
        total++;
        if (dut_v !== 79'd0) begin
          bad++;
          $display("FAIL rst_mid_zero cyc=%0d got=%h want=0", cyc, dut_v);
        end
      end
      if (k == 11) begin
        total++;
        if (wr_en !== 4'b0001 || wr_addr[7:0] !== 8'd0) begin
          bad++;
          $display("FAIL rst_restart cyc=%0d en=%b addr0=%0d want en=0001 addr0=0", cyc,
                   wr_en, wr_addr[7:0]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic w, r, a, rs;
    logic [15:0] n;
    for (int k = 0; k < 500; k++) begin
      rs = ($urandom_range(0, 99) == 0);
      w  = !rs && ($urandom_range(0, 4) == 0);
      r  = !rs && ($urandom_range(0, 4) == 0);
      a  = 1'($urandom_range(0, 1));
      n  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(9, 300)) : 16'($urandom_range(0, 8));
      tick(w, r, a, n, rs);
      model_eval(cyc);
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h want=%h", cyc, dut_v, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr_start_in = 1'b0; rd_start_in = 1'b0; accum_in = 1'b0; num_row = 16'd0;
    test_reset();
    test_write_overwrite();
    test_write_accum();
    test_read();
    test_clamp_zero();
    test_start_handling();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
